// File: rtl/rect_issue_pacer.sv
// rect_issue_pacer: range-checks rectangle requests, queues them in a FIFO and issues one per 4-cycle slot.
// Define PACER_STATS_EN to add saturating accept/reject/bubble counters.
module rect_issue_pacer #(
    parameter int FIFO_DEPTH     = 8,
    parameter int ISSUE_PHASE    = 0,
    parameter int RESULT_LATENCY = 32,
    parameter int DIM_MIN        = 4,
    parameter int DIM_MAX        = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [4:0]                    req_width_i,
    input  logic [4:0]                    req_height_i,
    output logic [4:0]                    width_o,
    output logic [4:0]                    height_o,
    output logic                          issue_o,
    output logic [1:0]                    slot_o,
    output logic                          res_valid_o,
    output logic                          reject_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef PACER_STATS_EN
    ,
    output logic [15:0]                   accept_cnt_o,
    output logic [15:0]                   reject_cnt_o,
    output logic [15:0]                   bubble_cnt_o
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [4:0]    DIM_MIN_C = 5'(DIM_MIN);
    localparam logic [4:0]    DIM_MAX_C = 5'(DIM_MAX);
    localparam logic [1:0]    PHASE_C   = 2'(ISSUE_PHASE);

    typedef struct packed {
        logic [4:0] w;
        logic [4:0] h;
    } rect_t;

    rect_t                     mem_q [FIFO_DEPTH];
    logic [AW-1:0]             wptr_q, wptr_d;
    logic [AW-1:0]             rptr_q, rptr_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      ready_q, ready_d;
    logic [1:0]                slot_q, slot_d;
    rect_t                     out_q, out_d;
    logic                      issue_q, issue_d;
    logic                      reject_q, reject_d;
    // RESULT_LATENCY must be >= 2; tap [RESULT_LATENCY-1] lags issue_q by exactly RESULT_LATENCY cycles.
    logic [RESULT_LATENCY-1:0] res_sr_q, res_sr_d;

    logic hs;
    logic legal;
    logic push;
    logic pop;
    logic issue_slot;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
        hs         = req_valid_i & ready_q;
        legal      = (req_width_i  >= DIM_MIN_C) && (req_width_i  <= DIM_MAX_C) &&
                     (req_height_i >= DIM_MIN_C) && (req_height_i <= DIM_MAX_C);
        push       = hs & legal;
        issue_slot = (slot_q == PHASE_C);
        pop        = issue_slot && (count_q != '0);

        wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d   = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
        // Ready tracks next-cycle occupancy only, so a full FIFO cannot accept in the cycle it pops.
        ready_d  = (count_d < DEPTH_C);
        slot_d   = slot_q + 2'd1;

        out_d    = out_q;
        issue_d  = 1'b0;
        if (issue_slot) begin
            issue_d = pop;
            out_d   = pop ? mem_q[rptr_q] : '0;
        end

        reject_d = hs & ~legal;
        res_sr_d = {res_sr_q[RESULT_LATENCY-2:0], issue_q};
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
            slot_q   <= 2'd0;
            out_q    <= '0;
            issue_q  <= 1'b0;
            reject_q <= 1'b0;
            res_sr_q <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
            slot_q   <= slot_d;
            out_q    <= out_d;
            issue_q  <= issue_d;
            reject_q <= reject_d;
            res_sr_q <= res_sr_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= {req_width_i, req_height_i};
        end
    end

`ifdef PACER_STATS_EN
    logic [15:0] accept_cnt_q, reject_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            accept_cnt_q <= '0;
            reject_cnt_q <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (push && accept_cnt_q != 16'hFFFF) begin
                accept_cnt_q <= accept_cnt_q + 16'd1;
            end
            if (reject_d && reject_cnt_q != 16'hFFFF) begin
                reject_cnt_q <= reject_cnt_q + 16'd1;
            end
            if (issue_slot && !pop && bubble_cnt_q != 16'hFFFF) begin
                bubble_cnt_q <= bubble_cnt_q + 16'd1;
            end
        end
    end

    assign accept_cnt_o = accept_cnt_q;
    assign reject_cnt_o = reject_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

    assign req_ready_o  = ready_q;
    assign width_o      = out_q.w;
    assign height_o     = out_q.h;
    assign issue_o      = issue_q;
    assign slot_o       = slot_q;
    assign res_valid_o  = res_sr_q[RESULT_LATENCY-1];
    assign reject_o     = reject_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_rect_issue_pacer.sv
// Bench for rect_issue_pacer: directed vector table plus hand-written multi-cycle sequences,
// with a cycle-level reference model of the FIFO, slot schedule and result latency.
module tb_rect_issue_pacer;

    localparam int         DEPTH = 8;
    localparam int         RL    = 32;
    localparam logic [1:0] PHASE = 2'd0;

    typedef struct packed {
        logic [4:0] w;
        logic [4:0] h;
    } rect_t;

    typedef struct {
        logic [4:0] w;
        logic [4:0] h;
        logic       exp_rej;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [4:0] req_width_i = '0;
    logic [4:0] req_height_i = '0;
    logic [4:0] width_o;
    logic [4:0] height_o;
    logic       issue_o;
    logic [1:0] slot_o;
    logic       res_valid_o;
    logic       reject_o;
    logic [3:0] fifo_count_o;
`ifdef PACER_STATS_EN
    logic [15:0] accept_cnt;
    logic [15:0] reject_cnt;
    logic [15:0] bubble_cnt;
`endif

    rect_issue_pacer #(
        .FIFO_DEPTH(DEPTH), .ISSUE_PHASE(0), .RESULT_LATENCY(RL), .DIM_MIN(4), .DIM_MAX(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_width_i(req_width_i), .req_height_i(req_height_i),
        .width_o(width_o), .height_o(height_o), .issue_o(issue_o), .slot_o(slot_o),
        .res_valid_o(res_valid_o), .reject_o(reject_o), .fifo_count_o(fifo_count_o)
`ifdef PACER_STATS_EN
        , .accept_cnt_o(accept_cnt), .reject_cnt_o(reject_cnt), .bubble_cnt_o(bubble_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    int    tests = 0;
    int    fails = 0;
    bit    mon_en = 0;
    rect_t model_q[$];
    int    resv_q[$];
    int    cyc = 0;
    logic [1:0] mslot = 2'd0;
    bit    pop_prev = 0;
    bit    prev_phase = 0;
    bit    first_cyc = 1;
    rect_t pend;
    int    acc_n = 0;
    int    rej_n = 0;
    vec_t  vecs[10];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference slot counter, restarted by every reset edge.
    always @(posedge clk_i) begin
        cyc++;
        if (!rst_i) mslot = 2'd0;
        else        mslot = mslot + 2'd1;
    end

    // Cycle model: pops at the issue phase, registered issue/width one cycle later, results RL cycles on.
    always @(negedge clk_i) begin
        if (!mon_en) begin
            resv_q.delete();
            pop_prev   = 0;
            prev_phase = 0;
            first_cyc  = 1;
        end else begin
            bit exp_rv;
            check("slot", slot_o, mslot);
            check("issue", issue_o, pop_prev);
            if (pop_prev) begin
                check("issue_width", width_o, pend.w);
                check("issue_height", height_o, pend.h);
                resv_q.push_back(cyc + RL);
            end else if (prev_phase) begin
                check("bubble_width", width_o, 0);
                check("bubble_height", height_o, 0);
            end
            exp_rv = (resv_q.size() > 0) && (resv_q[0] == cyc);
            if (exp_rv) void'(resv_q.pop_front());
            check("res_valid", res_valid_o, exp_rv);
            check("fifo_count", fifo_count_o, model_q.size());
            check("ready", req_ready_o, first_cyc ? 0 : int'(model_q.size() < DEPTH));
            first_cyc  = 0;
            prev_phase = (mslot == PHASE);
            pop_prev   = prev_phase && (model_q.size() > 0);
            if (pop_prev) pend = model_q.pop_front();
        end
    end

    task automatic do_reset(input int n);
        mon_en      = 0;
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        model_q.delete();
        acc_n = 0;
        rej_n = 0;
        repeat (n) tick();
        check("rst_width", width_o, 0);
        check("rst_height", height_o, 0);
        check("rst_issue", issue_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_reject", reject_o, 0);
        check("rst_count", fifo_count_o, 0);
        check("rst_ready", req_ready_o, 0);
        check("rst_slot", slot_o, 0);
        rst_i  = 1'b1;
        mon_en = 1;
    endtask

    task automatic push(input logic [4:0] w, input logic [4:0] h);
        int n = 0;
        req_valid_i = 1'b0;
        while (!req_ready_o && n < 64) begin
            tick();
            n++;
        end
        check("push_ready", req_ready_o, 1);
        req_valid_i  = 1'b1;
        req_width_i  = w;
        req_height_i = h;
        tick();
        req_valid_i = 1'b0;
        if (w >= 4 && w <= 16 && h >= 4 && h <= 16) begin
            model_q.push_back({w, h});
            acc_n++;
        end else begin
            rej_n++;
        end
    endtask

    task automatic wait_slot(input logic [1:0] s);
        int n = 0;
        while (slot_o != s && n < 8) begin
            tick();
            n++;
        end
        check("wait_slot", slot_o, s);
    endtask

    task automatic drain();
        int n = 0;
        while (fifo_count_o != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain", fifo_count_o, 0);
        repeat (RL + 8) tick();
    endtask

    initial begin
        int n;
        bit saw;
        vecs[0] = '{5'd3,  5'd6,  1'b1};
        vecs[1] = '{5'd17, 5'd4,  1'b1};
        vecs[2] = '{5'd0,  5'd0,  1'b1};
        vecs[3] = '{5'd4,  5'd17, 1'b1};
        vecs[4] = '{5'd16, 5'd3,  1'b1};
        vecs[5] = '{5'd31, 5'd31, 1'b1};
        vecs[6] = '{5'd4,  5'd4,  1'b0};
        vecs[7] = '{5'd16, 5'd16, 1'b0};
        vecs[8] = '{5'd10, 5'd12, 1'b0};
        vecs[9] = '{5'd7,  5'd9,  1'b0};

        // Reset held 3 cycles, then the slot counter runs 0,1,2,3,0 with bubbles.
        do_reset(3);
        for (int i = 0; i < 5; i++) begin
            check("t1_slot", slot_o, i % 4);
            check("t1_width", width_o, 0);
            tick();
        end

        // Single 8x5 request into an empty FIFO during slot 1.
        wait_slot(2'd1);
        push(5'd8, 5'd5);
        n = 0;
        while (!issue_o && n < 8) begin
            tick();
            n++;
        end
        check("t2_issue_latency", n, 3);
        check("t2_width", width_o, 8);
        check("t2_height", height_o, 5);
        for (int k = 1; k <= RL; k++) begin
            tick();
            if (k < 4) check("t2_hold_width", width_o, 8);
            if (k == RL - 1) check("t2_res_early", res_valid_o, 0);
            if (k == RL) check("t2_res_valid", res_valid_o, 1);
        end
        drain();

        // Range-check table: rejects first (FIFO stays empty), then legal boundary sizes.
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].w, vecs[i].h);
            check("tbl_reject", reject_o, vecs[i].exp_rej);
            if (vecs[i].exp_rej) check("tbl_count", fifo_count_o, 0);
            tick();
            check("tbl_reject_pulse", reject_o, 0);
        end
        drain();

        // Ten back-to-back legal requests starting at slot 1 fill the FIFO to 8.
        wait_slot(2'd1);
        for (int i = 0; i < 10; i++) begin
            push(5'(4 + i), 5'(13 - i));
        end
        check("t3_full", fifo_count_o, DEPTH);
        check("t3_ready_low", req_ready_o, 0);
        saw = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (req_ready_o) saw = 1;
        end
        check("t3_ready_back", saw, 1);
        drain();

        // Reset at slot 2 right after an issue discards queued and in-flight requests.
        wait_slot(2'd1);
        push(5'd5, 5'd5);
        push(5'd6, 5'd6);
        push(5'd7, 5'd7);
        push(5'd9, 5'd9);
        check("t5_issue_before_rst", issue_o, 1);
        tick();
        check("t5_slot2", slot_o, 2);
        do_reset(2);
        repeat (RL + 8) tick();
        push(5'd6, 5'd7);
        n = 0;
        while (!issue_o && n < 8) begin
            tick();
            n++;
        end
        check("t5_new_issue", issue_o, 1);
        check("t5_new_width", width_o, 6);
        drain();

`ifdef PACER_STATS_EN
        check("stats_accept", accept_cnt, acc_n);
        check("stats_reject", reject_cnt, rej_n);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
